// File: rtl/cp0_timer.sv
// MIPS-style CP0 subset: BadVAddr, Count/Compare timer, Status, Cause and EPC.
// Reads are combinational; MTC0 writes, exception commit and ERET update on clk.
module cp0_timer #(
    parameter int HW_INT_N  = 6,
    parameter int COUNT_DIV = 2,
    parameter int TIMER_EN  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [HW_INT_N-1:0] hint,
    input  logic [7:0]          raddr,
    output logic [31:0]         rdata,
    input  logic                wen,
    input  logic [7:0]          waddr,
    input  logic [31:0]         wdata,
    input  logic                mem_stall,
    input  logic                exp_en,
    input  logic                exp_badvaddr_en,
    input  logic [31:0]         exp_badvaddr,
    input  logic                exp_bd,
    input  logic [4:0]          exp_code,
    input  logic [31:0]         exp_epc,
    input  logic                eret,
    output logic [31:0]         epc_address,
    output logic                allow_interrupt,
    output logic [7:0]          interrupt_flag,
    output logic                timer_int
);

    // Register addresses as {reg[4:0], sel[2:0]}
    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [31:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   compare_q, compare_d;
    logic [7:0]    im_q, im_d;
    logic          exl_q, exl_d;
    logic          ie_q, ie_d;
    logic          bd_q, bd_d;
    logic          ti_q, ti_d;
    logic [1:0]    ip_sw_q, ip_sw_d;
    logic [5:0]    ip_hw_q, ip_hw_d;
    logic [4:0]    exc_code_q, exc_code_d;
    logic [31:0]   badvaddr_q, badvaddr_d;
    logic [31:0]   epc_q, epc_d;

    logic [5:0]    hint_pad;
    logic [31:0]   status_rd;
    logic [31:0]   cause_rd;
    logic          presc_wrap;
    logic          exp_commit;
    logic          eret_commit;

    // Widen hint to six lines; lines beyond HW_INT_N read as zero
    always_comb begin
        hint_pad = '0;
        hint_pad[HW_INT_N-1:0] = hint;
    end

    // Assemble architectural Status/Cause views (BEV hard-wired to 1, IP7 merges timer)
    always_comb begin
        status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
        cause_rd  = {bd_q, ti_q, 14'b0, ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q,
                     1'b0, exc_code_q, 2'b0};
    end

    // Combinational MFC0 read mux; unmapped addresses read zero
    always_comb begin
        case (raddr)
            ADDR_BADVADDR: rdata = badvaddr_q;
            ADDR_COUNT:    rdata = count_q;
            ADDR_COMPARE:  rdata = compare_q;
            ADDR_STATUS:   rdata = status_rd;
            ADDR_CAUSE:    rdata = cause_rd;
            ADDR_EPC:      rdata = epc_q;
            default:       rdata = 32'h0;
        endcase
    end

    // Next state: timer, then MTC0, then exception/ERET so exception fields win
    always_comb begin
        count_d    = count_q;
        presc_d    = presc_q;
        compare_d  = compare_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = hint_pad;
        exc_code_d = exc_code_q;
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;

        exp_commit  = exp_en & ~mem_stall;
        eret_commit = eret & ~mem_stall;
        presc_wrap  = (presc_q == PRESC_MAX);

        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        if (wen && waddr == ADDR_COUNT) begin
            // Loaded value holds for a full prescaler period; no match check this cycle
            count_d = wdata;
            presc_d = '0;
        end else if (presc_wrap) begin
            count_d = count_q + 32'd1;
            if (count_q == compare_q) begin
                ti_d = 1'b1;
            end
        end

        if (wen) begin
            case (waddr)
                ADDR_COMPARE: begin
                    compare_d = wdata;
                    ti_d      = 1'b0;
                end
                ADDR_STATUS: begin
                    im_d  = wdata[15:8];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                ADDR_CAUSE: ip_sw_d = wdata[9:8];
                ADDR_EPC:   epc_d   = wdata;
                default: ;
            endcase
        end

        if (TIMER_EN == 0) begin
            ti_d = 1'b0;
        end

        if (exp_commit) begin
            exl_d      = 1'b1;
            exc_code_d = exp_code;
            if (exp_badvaddr_en) begin
                badvaddr_d = exp_badvaddr;
            end
            // Nested exceptions keep the original return point
            if (!exl_q) begin
                epc_d = exp_epc;
                bd_d  = exp_bd;
            end
        end else if (eret_commit) begin
            exl_d = 1'b0;
        end
    end

    // Resettable CP0 state
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            presc_q    <= '0;
            compare_q  <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            exc_code_q <= '0;
        end else begin
            count_q    <= count_d;
            presc_q    <= presc_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            exc_code_q <= exc_code_d;
        end
    end

    // BadVAddr and EPC survive reset
    always_ff @(posedge clk) begin
        badvaddr_q <= badvaddr_d;
        epc_q      <= epc_d;
    end

    // Output views
    always_comb begin
        epc_address     = epc_q;
        allow_interrupt = (status_rd[2:0] == 3'b001);
        interrupt_flag  = im_q & cause_rd[15:8];
        timer_int       = ti_q;
    end

endmodule
